// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALUControl encodings (3-bit)
//   - arbiter FSM state enum
//   - is_legal_op() helper used to gate illegal codes out of the response
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// alu: single shared combinational ALU datapath.
//   a, b   : 32-bit operands
//   op     : ALUControl code
//   result : ALU result (0 for illegal codes; caller must not trust it then)
//   zero   : result == 0
//   legal  : op is one of the defined codes
// One 33-bit adder serves add, sub and unsigned set-less-than; SLT reads the
// borrow of a - b, so there is no separate comparator.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zero,
  output logic        legal
);

  logic        sub;
  logic [32:0] sum;

  assign sub = (op == ALU_SUB) || (op == ALU_SLT);
  // a + ~b + 1 == a - b; carry-out is 1 exactly when a >= b (unsigned)
  assign sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'b0, sub};

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD, ALU_SUB: result = sum[31:0];
      ALU_AND:          result = a & b;
      ALU_OR:           result = a | b;
      ALU_SLT:          result = {31'b0, ~sum[32]};
      default:          result = '0;
    endcase
  end

  assign zero  = (result == '0);
  assign legal = is_legal_op(op);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin arbiter.
//   clk, reset            : clock, synchronous active-high reset
//   reqN_valid/ready      : request handshake per requester (ready is comb)
//   reqN_a, reqN_b, reqN_op: operands and ALUControl code per requester
//   rsp_valid/ready       : response handshake toward the consumer
//   rsp_id, rsp_result, rsp_zero, rsp_err : registered response fields
// IDLE accepts at most one op; RESP holds it until rsp_ready, so the peak rate
// is one op every two cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RR_RESET_LAST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam logic RST_LAST = RR_RESET_LAST[0];

  state_t      state;
  logic        last;
  logic        gsel;
  logic        accept;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_legal;

  // Both valid: pick the one not granted last. Otherwise pick whichever is
  // valid (gsel is don't-care when neither is).
  assign gsel = req1_valid & (~req0_valid | ~last);

  assign req0_ready = (state == IDLE) & ~reset & req0_valid & ~gsel;
  assign req1_ready = (state == IDLE) & ~reset & req1_valid &  gsel;
  assign accept     = req0_ready | req1_ready;

  assign alu_a  = gsel ? req1_a  : req0_a;
  assign alu_b  = gsel ? req1_b  : req0_b;
  assign alu_op = gsel ? req1_op : req0_op;

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero),
    .legal  (alu_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= RST_LAST;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state      <= RESP;
          last       <= gsel;
          rsp_valid  <= 1'b1;
          rsp_id     <= gsel;
          // illegal codes report a fixed 0 result rather than ALU output
          rsp_result <= alu_legal ? alu_res  : '0;
          rsp_zero   <= alu_legal ? alu_zero : 1'b1;
          rsp_err    <= ~alu_legal;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_RESET_LAST(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference ALU from the op definitions.
  task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output logic [31:0] r, output logic z, output logic e);
    e = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    z = (r == 32'd0);
  endtask

  task automatic negedge_in();
    @(negedge clk);
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp_ready = 0;
  endtask

  task automatic do_reset();
    negedge_in();
    idle_inputs();
    reset = 1;
    after_pos();
    after_pos();
    negedge_in();
    reset = 0;
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero, err;
  } vec_t;

  vec_t tbl[10];

  // random-phase model state
  bit          m_pend, m_last, m_id, m_zero, m_err;
  logic [31:0] m_res;

  initial begin
    reset = 1;
    idle_inputs();

    // ---- reset: readies low while reset is high, response regs cleared
    negedge_in();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("reset_ready0", 32'(req0_ready), 32'd0);
    chk("reset_ready1", 32'(req1_ready), 32'd0);
    after_pos();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    do_reset();

    // ---- table-driven single ops
    tbl[0] = '{1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'd0, 32'd1, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'd7, 32'd3, 3'b111, 32'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 32'd3, 32'hFFFFFFFF, 3'b101, 32'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h0000F0F0, 32'h0000FF00, 3'b010, 32'h0000F000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h0000F0F0, 32'h00000FFF, 3'b011, 32'h0000FFFF, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'd5, 32'd3, 3'b101, 32'd0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 32'd1, 32'd2, 3'b100, 32'd0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      negedge_in();
      idle_inputs();
      rsp_ready = 1;
      if (tbl[i].id) begin
        req1_valid = 1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_op = tbl[i].op;
        req0_a = 32'h1234; req0_b = 32'h5678; req0_op = 3'b000;
      end else begin
        req0_valid = 1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_op = tbl[i].op;
        req1_a = 32'h1234; req1_b = 32'h5678; req1_op = 3'b000;
      end
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(!tbl[i].id));
      chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].id));
      after_pos();
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
      chk($sformatf("v%0d_result", i), rsp_result, tbl[i].res);
      chk($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(tbl[i].zero));
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(tbl[i].err));
      negedge_in();
      req0_valid = 0; req1_valid = 0;
      after_pos();
      chk($sformatf("v%0d_drain", i), 32'(rsp_valid), 32'd0);
    end

    // ---- both valid continuously: grants 0,1,0,1 one every two cycles
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) negedge_in();
      #1;
      chk($sformatf("rr%0d_ready0", k), 32'(req0_ready), 32'((k % 2 == 0) && ((k / 2) % 2 == 0)));
      chk($sformatf("rr%0d_ready1", k), 32'(req1_ready), 32'((k % 2 == 0) && ((k / 2) % 2 == 1)));
      after_pos();
    end

    // ---- back-pressure: response held for 3 cycles
    negedge_in();
    idle_inputs();
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000;
    after_pos();
    chk("bp_accept_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      negedge_in();
      req0_valid = 1; req1_valid = 1; rsp_ready = 0;
      req0_a = 32'd1; req0_op = 3'b001;
      #1;
      chk($sformatf("bp%0d_ready0", k), 32'(req0_ready), 32'd0);
      chk($sformatf("bp%0d_ready1", k), 32'(req1_ready), 32'd0);
      after_pos();
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_id", k), 32'(rsp_id), 32'd0);
      chk($sformatf("bp%0d_result", k), rsp_result, 32'd30);
      chk($sformatf("bp%0d_zero_err", k), {30'd0, rsp_zero, rsp_err}, 32'd0);
    end
    negedge_in();
    rsp_ready = 1;
    #1;
    chk("bp_release_ready0", 32'(req0_ready), 32'd0);
    after_pos();
    chk("bp_release_idle", 32'(rsp_valid), 32'd0);

    // ---- reset while in RESP discards response, round-robin restarts at 0
    negedge_in();
    idle_inputs();
    req1_valid = 1; req1_a = 32'd4; req1_b = 32'd1; req1_op = 3'b001;
    after_pos();
    chk("rr_resp_valid", 32'(rsp_valid), 32'd1);
    chk("rr_resp_result", rsp_result, 32'd3);
    negedge_in();
    reset = 1; rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    #1;
    chk("rstresp_ready0", 32'(req0_ready), 32'd0);
    chk("rstresp_ready1", 32'(req1_ready), 32'd0);
    after_pos();
    chk("rstresp_valid", 32'(rsp_valid), 32'd0);
    chk("rstresp_result", rsp_result, 32'd0);
    negedge_in();
    reset = 0;
    #1;
    chk("rstresp_first0", 32'(req0_ready), 32'd1);
    chk("rstresp_first1", 32'(req1_ready), 32'd0);
    after_pos();
    chk("rstresp_first_id", 32'(rsp_id), 32'd0);

    // ---- randomized traffic against a transaction-level model
    do_reset();
    m_pend = 0; m_last = 1; m_id = 0; m_res = 0; m_zero = 0; m_err = 0;
    for (int c = 0; c < 400; c++) begin
      bit          g_any, g_sel;
      logic [31:0] ea, eb, er;
      logic [2:0]  eo;
      logic        ez, ee;
      negedge_in();
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g_any = !m_pend && (req0_valid || req1_valid);
      if (req0_valid && req1_valid) g_sel = !m_last;
      else                          g_sel = req1_valid;
      chk($sformatf("rnd%0d_ready0", c), 32'(req0_ready), 32'(g_any && !g_sel));
      chk($sformatf("rnd%0d_ready1", c), 32'(req1_ready), 32'(g_any && g_sel));
      if (m_pend) begin
        if (rsp_ready) m_pend = 0;
      end else if (g_any) begin
        ea = g_sel ? req1_a : req0_a;
        eb = g_sel ? req1_b : req0_b;
        eo = g_sel ? req1_op : req0_op;
        ref_alu(ea, eb, eo, er, ez, ee);
        m_pend = 1; m_last = g_sel; m_id = g_sel;
        m_res = er; m_zero = ez; m_err = ee;
      end
      after_pos();
      chk($sformatf("rnd%0d_valid", c), 32'(rsp_valid), 32'(m_pend));
      if (m_pend) begin
        chk($sformatf("rnd%0d_id", c), 32'(rsp_id), 32'(m_id));
        chk($sformatf("rnd%0d_result", c), rsp_result, m_res);
        chk($sformatf("rnd%0d_zero", c), 32'(rsp_zero), 32'(m_zero));
        chk($sformatf("rnd%0d_err", c), 32'(rsp_err), 32'(m_err));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
